// File: rtl/conv2d_mac_sequencer.sv
// conv2d_mac_sequencer
//   Four-lane 2-D convolution core. It walks every output position of a
//   CHANNELS x INPUT_HEIGHT x INPUT_WIDTH input, one pass of four kernels at
//   a time. It drives registered weight/input read addresses and accumulates
//   the operands the external buffers return combinationally. After the last
//   MAC of each position it strobes write_k together with out_k_address.
//
// Ports
//   clk, rst              clock (rising edge), asynchronous active-high reset
//   start                 begin one full convolution (honoured only when idle)
//   busy, done            run in progress / one-cycle pulse after final write
//   w_in_k_address        lane-k weight read address       (k = 1..4)
//   x_in_k_address        lane-k input read address        (k = 1..4)
//   w_in_k, x_in_k        signed 8-bit operands for the current addresses
//   out_k                 lane-k signed 16-bit accumulator
//   out_k_address         output buffer address of out_k
//   write_k               out_k is final for this position
//   clear, valid          accumulator control (clear on first MAC of a position)
//
// States
//   S_IDLE  | waiting for start
//   S_MAC   | one (c, r, s) multiply-accumulate per cycle
//   S_WRITE | accumulators final, write strobe for active lanes
//   S_DONE  | one-cycle done pulse, then back to idle
module conv2d_mac_sequencer #(
    parameter int KERNEL_SIZE                = 3,
    parameter int KERNELS                    = 4,
    parameter int STRIDE                     = 1,
    parameter int PADDING                    = 0,
    parameter int INPUT_WIDTH                = 5,
    parameter int INPUT_HEIGHT               = 5,
    parameter int CHANNELS                   = 3,
    parameter int WEIGHT_BUFFER_ADDRESS_BITS = 8,
    parameter int INPUT_BUFFER_ADDRESS_BITS  = 8,
    parameter int OUTPUT_BUFFER_ADDRESS_BITS = 7
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  start,
    output logic                                  busy,
    output logic                                  done,
    output logic [WEIGHT_BUFFER_ADDRESS_BITS-1:0] w_in_1_address,
    output logic [WEIGHT_BUFFER_ADDRESS_BITS-1:0] w_in_2_address,
    output logic [WEIGHT_BUFFER_ADDRESS_BITS-1:0] w_in_3_address,
    output logic [WEIGHT_BUFFER_ADDRESS_BITS-1:0] w_in_4_address,
    output logic [INPUT_BUFFER_ADDRESS_BITS-1:0]  x_in_1_address,
    output logic [INPUT_BUFFER_ADDRESS_BITS-1:0]  x_in_2_address,
    output logic [INPUT_BUFFER_ADDRESS_BITS-1:0]  x_in_3_address,
    output logic [INPUT_BUFFER_ADDRESS_BITS-1:0]  x_in_4_address,
    input  logic signed [7:0]                     w_in_1,
    input  logic signed [7:0]                     w_in_2,
    input  logic signed [7:0]                     w_in_3,
    input  logic signed [7:0]                     w_in_4,
    input  logic signed [7:0]                     x_in_1,
    input  logic signed [7:0]                     x_in_2,
    input  logic signed [7:0]                     x_in_3,
    input  logic signed [7:0]                     x_in_4,
    output logic signed [15:0]                    out_1,
    output logic signed [15:0]                    out_2,
    output logic signed [15:0]                    out_3,
    output logic signed [15:0]                    out_4,
    output logic [OUTPUT_BUFFER_ADDRESS_BITS-1:0] out_1_address,
    output logic [OUTPUT_BUFFER_ADDRESS_BITS-1:0] out_2_address,
    output logic [OUTPUT_BUFFER_ADDRESS_BITS-1:0] out_3_address,
    output logic [OUTPUT_BUFFER_ADDRESS_BITS-1:0] out_4_address,
    output logic                                  write_1,
    output logic                                  write_2,
    output logic                                  write_3,
    output logic                                  write_4,
    output logic                                  clear,
    output logic                                  valid
);
    localparam int WAB       = WEIGHT_BUFFER_ADDRESS_BITS;
    localparam int IAB       = INPUT_BUFFER_ADDRESS_BITS;
    localparam int OAB       = OUTPUT_BUFFER_ADDRESS_BITS;
    localparam int OH        = (INPUT_HEIGHT + 2 * PADDING - KERNEL_SIZE) / STRIDE + 1;
    localparam int OW        = (INPUT_WIDTH + 2 * PADDING - KERNEL_SIZE) / STRIDE + 1;
    localparam int KK        = KERNEL_SIZE * KERNEL_SIZE;
    localparam int KKC       = KK * CHANNELS;
    localparam int HW        = INPUT_HEIGHT * INPUT_WIDTH;
    localparam int OHW       = OH * OW;
    localparam int ZERO_SLOT = HW * CHANNELS;
    localparam int NPASS     = (KERNELS + 3) / 4;

    localparam logic [7:0] C_LAST  = 8'(CHANNELS - 1);
    localparam logic [7:0] K_LAST  = 8'(KERNEL_SIZE - 1);
    localparam logic [7:0] OW_LAST = 8'(OW - 1);
    localparam logic [7:0] OH_LAST = 8'(OH - 1);
    localparam logic [7:0] P_LAST  = 8'(NPASS - 1);

    typedef enum logic [1:0] {S_IDLE, S_MAC, S_WRITE, S_DONE} state_t;

    state_t state_q, state_d;
    logic [7:0] pass_q, pass_d, oy_q, oy_d, ox_q, ox_d;
    logic [7:0] c_q, c_d, r_q, r_d, s_q, s_d;

    logic [WAB-1:0]     w_addr_q [4];
    logic [WAB-1:0]     w_addr_d [4];
    logic [IAB-1:0]     x_addr_q [4];
    logic [IAB-1:0]     x_addr_d [4];
    logic [OAB-1:0]     o_addr_q [4];
    logic [OAB-1:0]     o_addr_d [4];
    logic signed [15:0] acc_q [4];
    logic signed [15:0] acc_d [4];
    logic signed [7:0]  w_op [4];
    logic signed [7:0]  x_op [4];
    logic [3:0]         write_q, write_d;
    logic               valid_q, valid_d, clear_q, clear_d;
    logic               busy_q, busy_d, done_q, done_d;

    int                 kern, y_pos, x_pos, w_idx, x_idx, o_idx;
    logic               in_range;
    logic signed [15:0] prod;

    assign w_op[0] = w_in_1;
    assign w_op[1] = w_in_2;
    assign w_op[2] = w_in_3;
    assign w_op[3] = w_in_4;
    assign x_op[0] = x_in_1;
    assign x_op[1] = x_in_2;
    assign x_op[2] = x_in_3;
    assign x_op[3] = x_in_4;

    // Sequencing: s innermost, then r, then c; positions ox then oy; then pass.
    always_comb begin
        state_d = state_q;
        pass_d  = pass_q;
        oy_d    = oy_q;
        ox_d    = ox_q;
        c_d     = c_q;
        r_d     = r_q;
        s_d     = s_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_MAC;
                    pass_d  = '0;
                    oy_d    = '0;
                    ox_d    = '0;
                    c_d     = '0;
                    r_d     = '0;
                    s_d     = '0;
                end
            end
            S_MAC: begin
                if (c_q == C_LAST && r_q == K_LAST && s_q == K_LAST) begin
                    state_d = S_WRITE;
                end else if (s_q == K_LAST) begin
                    s_d = '0;
                    if (r_q == K_LAST) begin
                        r_d = '0;
                        c_d = c_q + 8'd1;
                    end else begin
                        r_d = r_q + 8'd1;
                    end
                end else begin
                    s_d = s_q + 8'd1;
                end
            end
            S_WRITE: begin
                state_d = S_MAC;
                c_d     = '0;
                r_d     = '0;
                s_d     = '0;
                if (ox_q == OW_LAST) begin
                    ox_d = '0;
                    if (oy_q == OH_LAST) begin
                        oy_d = '0;
                        if (pass_q == P_LAST) begin
                            pass_d  = '0;
                            state_d = S_DONE;
                        end else begin
                            pass_d = pass_q + 8'd1;
                        end
                    end else begin
                        oy_d = oy_q + 8'd1;
                    end
                end else begin
                    ox_d = ox_q + 8'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Registered outputs are derived from the next-cycle counters so that
    // addresses and strobes are flop outputs, stable for the whole cycle.
    always_comb begin
        kern     = 0;
        w_idx    = 0;
        o_idx    = 0;
        prod     = '0;
        valid_d  = (state_d == S_MAC);
        clear_d  = valid_d && c_d == '0 && r_d == '0 && s_d == '0;
        busy_d   = (state_d == S_MAC) || (state_d == S_WRITE);
        done_d   = (state_d == S_DONE);
        write_d  = '0;
        y_pos    = int'(oy_d) * STRIDE + int'(r_d) - PADDING;
        x_pos    = int'(ox_d) * STRIDE + int'(s_d) - PADDING;
        in_range = (y_pos >= 0) && (y_pos < INPUT_HEIGHT) &&
                   (x_pos >= 0) && (x_pos < INPUT_WIDTH);
        // Padded taps read the dedicated zero slot instead of a real pixel.
        x_idx    = in_range ? int'(c_d) * HW + y_pos * INPUT_WIDTH + x_pos : ZERO_SLOT;
        for (int l = 0; l < 4; l++) begin
            kern  = int'(pass_d) * 4 + l;
            w_idx = kern * KKC + int'(c_d) * KK + int'(r_d) * KERNEL_SIZE + int'(s_d);
            o_idx = kern * OHW + int'(oy_d) * OW + int'(ox_d);
            w_addr_d[l] = valid_d ? WAB'(w_idx) : '0;
            x_addr_d[l] = valid_d ? IAB'(x_idx) : '0;
            o_addr_d[l] = (state_d == S_WRITE) ? OAB'(o_idx) : '0;
            write_d[l]  = (state_d == S_WRITE) && (kern < KERNELS);
            // Sign-extend to 16 bits first; the low 16 bits of the product are exact.
            prod     = 16'(w_op[l]) * 16'(x_op[l]);
            acc_d[l] = acc_q[l];
            if (valid_q) begin
                acc_d[l] = (clear_q ? 16'sd0 : acc_q[l]) + prod;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            pass_q  <= '0;
            oy_q    <= '0;
            ox_q    <= '0;
            c_q     <= '0;
            r_q     <= '0;
            s_q     <= '0;
            write_q <= '0;
            valid_q <= 1'b0;
            clear_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            for (int l = 0; l < 4; l++) begin
                w_addr_q[l] <= '0;
                x_addr_q[l] <= '0;
                o_addr_q[l] <= '0;
                acc_q[l]    <= '0;
            end
        end else begin
            state_q <= state_d;
            pass_q  <= pass_d;
            oy_q    <= oy_d;
            ox_q    <= ox_d;
            c_q     <= c_d;
            r_q     <= r_d;
            s_q     <= s_d;
            write_q <= write_d;
            valid_q <= valid_d;
            clear_q <= clear_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            for (int l = 0; l < 4; l++) begin
                w_addr_q[l] <= w_addr_d[l];
                x_addr_q[l] <= x_addr_d[l];
                o_addr_q[l] <= o_addr_d[l];
                acc_q[l]    <= acc_d[l];
            end
        end
    end

    assign busy           = busy_q;
    assign done           = done_q;
    assign valid          = valid_q;
    assign clear          = clear_q;
    assign w_in_1_address = w_addr_q[0];
    assign w_in_2_address = w_addr_q[1];
    assign w_in_3_address = w_addr_q[2];
    assign w_in_4_address = w_addr_q[3];
    assign x_in_1_address = x_addr_q[0];
    assign x_in_2_address = x_addr_q[1];
    assign x_in_3_address = x_addr_q[2];
    assign x_in_4_address = x_addr_q[3];
    assign out_1          = acc_q[0];
    assign out_2          = acc_q[1];
    assign out_3          = acc_q[2];
    assign out_4          = acc_q[3];
    assign out_1_address  = o_addr_q[0];
    assign out_2_address  = o_addr_q[1];
    assign out_3_address  = o_addr_q[2];
    assign out_4_address  = o_addr_q[3];
    assign write_1        = write_q[0];
    assign write_2        = write_q[1];
    assign write_3        = write_q[2];
    assign write_4        = write_q[3];
endmodule

// File: tb/tb_conv2d_mac_sequencer.sv
// Directed testbench for conv2d_mac_sequencer: a default instance and a
// PADDING=1 instance, each reading bench-owned weight and input memories.
module tb_conv2d_mac_sequencer;
    logic clk = 1'b0;
    logic rst, start, start_p;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic signed [7:0] wmem [256];
    logic signed [7:0] xmem [256];

    logic [7:0]         wa [4], xa [4], wa_p [4], xa_p [4];
    logic signed [7:0]  wv [4], xv [4], wv_p [4], xv_p [4];
    logic signed [15:0] ov [4], ov_p [4];
    logic [6:0]         oa [4], oa_p [4];
    logic [3:0]         wr, wr_p;
    logic               busy, done, clear, valid;
    logic               busy_p, done_p, clear_p, valid_p;

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            wv[i]   = wmem[wa[i]];
            xv[i]   = xmem[xa[i]];
            wv_p[i] = wmem[wa_p[i]];
            xv_p[i] = xmem[xa_p[i]];
        end
    end

    conv2d_mac_sequencer dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
        .w_in_1_address(wa[0]), .w_in_2_address(wa[1]), .w_in_3_address(wa[2]), .w_in_4_address(wa[3]),
        .x_in_1_address(xa[0]), .x_in_2_address(xa[1]), .x_in_3_address(xa[2]), .x_in_4_address(xa[3]),
        .w_in_1(wv[0]), .w_in_2(wv[1]), .w_in_3(wv[2]), .w_in_4(wv[3]),
        .x_in_1(xv[0]), .x_in_2(xv[1]), .x_in_3(xv[2]), .x_in_4(xv[3]),
        .out_1(ov[0]), .out_2(ov[1]), .out_3(ov[2]), .out_4(ov[3]),
        .out_1_address(oa[0]), .out_2_address(oa[1]), .out_3_address(oa[2]), .out_4_address(oa[3]),
        .write_1(wr[0]), .write_2(wr[1]), .write_3(wr[2]), .write_4(wr[3]),
        .clear(clear), .valid(valid)
    );

    conv2d_mac_sequencer #(.PADDING(1)) dut_p (
        .clk(clk), .rst(rst), .start(start_p), .busy(busy_p), .done(done_p),
        .w_in_1_address(wa_p[0]), .w_in_2_address(wa_p[1]), .w_in_3_address(wa_p[2]), .w_in_4_address(wa_p[3]),
        .x_in_1_address(xa_p[0]), .x_in_2_address(xa_p[1]), .x_in_3_address(xa_p[2]), .x_in_4_address(xa_p[3]),
        .w_in_1(wv_p[0]), .w_in_2(wv_p[1]), .w_in_3(wv_p[2]), .w_in_4(wv_p[3]),
        .x_in_1(xv_p[0]), .x_in_2(xv_p[1]), .x_in_3(xv_p[2]), .x_in_4(xv_p[3]),
        .out_1(ov_p[0]), .out_2(ov_p[1]), .out_3(ov_p[2]), .out_4(ov_p[3]),
        .out_1_address(oa_p[0]), .out_2_address(oa_p[1]), .out_3_address(oa_p[2]), .out_4_address(oa_p[3]),
        .write_1(wr_p[0]), .write_2(wr_p[1]), .write_3(wr_p[2]), .write_4(wr_p[3]),
        .clear(clear_p), .valid(valid_p)
    );

    // Direct convolution over the bench memories (K=3, C=3, H=W=5).
    function automatic logic signed [15:0] ref_out(input int kern, input int oy, input int ox, input int pad);
        int sum = 0;
        int y, x;
        for (int c = 0; c < 3; c++)
            for (int r = 0; r < 3; r++)
                for (int s = 0; s < 3; s++) begin
                    y = oy + r - pad;
                    x = ox + s - pad;
                    if (y >= 0 && y < 5 && x >= 0 && x < 5)
                        sum += int'(wmem[kern * 27 + c * 9 + r * 3 + s]) * int'(xmem[c * 25 + y * 5 + x]);
                end
        return 16'(sum);
    endfunction

    task automatic load_pattern();
        for (int i = 0; i < 256; i++) begin
            wmem[i] = 8'(i % 7);
            xmem[i] = 8'(i % 10);
        end
        xmem[75] = 8'sd0;
    endtask

    task automatic kick(input bit padded);
        repeat (2) @(negedge clk);
        if (padded) start_p = 1'b1; else start = 1'b1;
        @(posedge clk);
        #1;
        start   = 1'b0;
        start_p = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; start_p = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || valid !== 1'b0 || clear !== 1'b0 || wr !== 4'b0)
            begin failures++; $display("FAIL reset_ctrl busy=%b done=%b valid=%b clear=%b wr=%b want all 0", busy, done, valid, clear, wr); end
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (ov[k] !== 16'sd0 || oa[k] !== 7'd0 || wa[k] !== 8'd0 || xa[k] !== 8'd0)
                begin failures++; $display("FAIL reset_lane%0d out=%0d oa=%0d wa=%0d xa=%0d want 0", k + 1, ov[k], oa[k], wa[k], xa[k]); end
        end
        rst = 1'b0;
        repeat (20) begin
            @(negedge clk);
            checks++;
            if (valid !== 1'b0 || wr !== 4'b0 || busy !== 1'b0)
                begin failures++; $display("FAIL idle_hold valid=%b wr=%b busy=%b want 0", valid, wr, busy); end
        end
    endtask

    task automatic test_default_run();
        int nw [4];
        int done_cyc, first_wr, p;
        logic signed [15:0] e;
        nw = '{0, 0, 0, 0};
        done_cyc = 0; first_wr = 0;
        load_pattern();
        kick(1'b0);
        for (int cyc = 1; cyc <= 400; cyc++) begin
            @(negedge clk);
            if (cyc <= 27) begin
                checks++;
                if (wa[0] !== 8'(cyc - 1) || wa[1] !== 8'(26 + cyc) || valid !== 1'b1 || clear !== (cyc == 1))
                    begin failures++; $display("FAIL w_seq cyc=%0d wa1=%0d wa2=%0d valid=%b clear=%b want %0d %0d 1 %b", cyc, wa[0], wa[1], valid, clear, cyc - 1, 26 + cyc, cyc == 1); end
            end
            if (wr[0] && first_wr == 0) begin
                first_wr = cyc;
                checks++;
                if (cyc != 28 || ov[0] !== 16'sd232 || oa[0] !== 7'd0 || ov[1] !== 16'sd201 || oa[1] !== 7'd9 || valid !== 1'b0)
                    begin failures++; $display("FAIL first_write cyc=%0d out1=%0d a1=%0d out2=%0d a2=%0d valid=%b want 28 232 0 201 9 0", cyc, ov[0], oa[0], ov[1], oa[1], valid); end
            end
            for (int k = 0; k < 4; k++) begin
                if (wr[k]) begin
                    p = nw[k];
                    e = ref_out(k, p / 3, p % 3, 0);
                    checks++;
                    if (oa[k] !== 7'(k * 9 + p) || ov[k] !== e)
                        begin failures++; $display("FAIL write lane%0d n=%0d addr=%0d out=%0d want %0d %0d", k + 1, p, oa[k], ov[k], k * 9 + p, e); end
                    nw[k]++;
                end
            end
            if (done) begin
                done_cyc = cyc;
                break;
            end
        end
        checks++;
        if (done_cyc != 253 || busy !== 1'b0)
            begin failures++; $display("FAIL done_time got=%0d busy=%b want 253 0", done_cyc, busy); end
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (nw[k] != 9)
                begin failures++; $display("FAIL write_count lane%0d got=%0d want 9", k + 1, nw[k]); end
        end
    endtask

    task automatic test_start_while_busy();
        int done_cyc = 0;
        load_pattern();
        kick(1'b0);
        for (int cyc = 1; cyc <= 400; cyc++) begin
            @(negedge clk);
            start = (cyc == 50);
            if (done) begin
                done_cyc = cyc;
                break;
            end
        end
        checks++;
        if (done_cyc != 253)
            begin failures++; $display("FAIL busy_start done=%0d want 253", done_cyc); end
        start = 1'b1;   // asserted during the done cycle: must be ignored
        @(negedge clk);
        start = 1'b0;
        repeat (5) begin
            @(negedge clk);
            checks++;
            if (busy !== 1'b0 || valid !== 1'b0)
                begin failures++; $display("FAIL done_start busy=%b valid=%b want 0 0", busy, valid); end
        end
    endtask

    task automatic test_padding();
        int nw [4];
        int exp_x [5];
        int done_cyc, p;
        logic signed [15:0] e;
        nw = '{0, 0, 0, 0};
        exp_x = '{75, 75, 75, 75, 0};
        done_cyc = 0;
        load_pattern();
        kick(1'b1);
        for (int cyc = 1; cyc <= 800; cyc++) begin
            @(negedge clk);
            if (cyc <= 5) begin
                checks++;
                if (xa_p[0] !== 8'(exp_x[cyc - 1]))
                    begin failures++; $display("FAIL pad_xaddr cyc=%0d got=%0d want %0d", cyc, xa_p[0], exp_x[cyc - 1]); end
            end
            for (int k = 0; k < 4; k++) begin
                if (wr_p[k]) begin
                    p = nw[k];
                    e = ref_out(k, p / 5, p % 5, 1);
                    checks++;
                    if (oa_p[k] !== 7'(k * 25 + p) || ov_p[k] !== e)
                        begin failures++; $display("FAIL pad_write lane%0d n=%0d addr=%0d out=%0d want %0d %0d", k + 1, p, oa_p[k], ov_p[k], k * 25 + p, e); end
                    nw[k]++;
                end
            end
            if (done_p) begin
                done_cyc = cyc;
                break;
            end
        end
        checks++;
        if (done_cyc != 701 || nw[0] != 25 || nw[3] != 25)
            begin failures++; $display("FAIL pad_done cyc=%0d n1=%0d n4=%0d want 701 25 25", done_cyc, nw[0], nw[3]); end
    endtask

    task automatic test_reset_mid_run();
        load_pattern();
        kick(1'b0);
        repeat (99) @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if (busy !== 1'b0 || valid !== 1'b0 || clear !== 1'b0 || done !== 1'b0 || wr !== 4'b0 ||
            ov[0] !== 16'sd0 || ov[3] !== 16'sd0 || wa[0] !== 8'd0 || xa[0] !== 8'd0 || oa[0] !== 7'd0)
            begin failures++; $display("FAIL mid_reset busy=%b valid=%b wr=%b out1=%0d wa1=%0d xa1=%0d want all 0", busy, valid, wr, ov[0], wa[0], xa[0]); end
        @(negedge clk);
        rst = 1'b0;
        repeat (60) begin
            @(negedge clk);
            checks++;
            if (wr !== 4'b0 || busy !== 1'b0 || valid !== 1'b0)
                begin failures++; $display("FAIL post_reset wr=%b busy=%b valid=%b want 0", wr, busy, valid); end
        end
    endtask

    task automatic test_wrap();
        int first_wr = 0;
        int done_cyc = 0;
        for (int i = 0; i < 256; i++) begin
            wmem[i] = 8'sd127;
            xmem[i] = 8'sd127;
        end
        kick(1'b0);
        for (int cyc = 1; cyc <= 400; cyc++) begin
            @(negedge clk);
            if (wr[0] && first_wr == 0) begin
                first_wr = cyc;
                checks++;
                if (ov[0] !== -16'sd23269 || ov[3] !== -16'sd23269)
                    begin failures++; $display("FAIL wrap out1=%0d out4=%0d want -23269", ov[0], ov[3]); end
            end
            if (done) begin
                done_cyc = cyc;
                break;
            end
        end
        checks++;
        if (first_wr != 28 || done_cyc != 253)
            begin failures++; $display("FAIL wrap_timing first=%0d done=%0d want 28 253", first_wr, done_cyc); end
    endtask

    initial begin
        test_reset();
        test_default_run();
        test_start_while_busy();
        test_padding();
        test_reset_mid_run();
        test_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
